mdu_ctrl: RTL

Multi-cycle multiply/divide sequencer for the MIPS core, owning the HI/LO register pair. It accepts MULT/MULTU/DIV/DIVU from the EX stage and iterates one 33-bit add/subtract per cycle, 32 iterations, with sign pre/post-correction. It presents `busy` so the pipeline can stall on MFHI/MFLO. It also services MTHI/MTLO writes.

---
 rtl/mdu_ctrl.sv | 298 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/mdu_ctrl.sv
// mdu_ctrl -- multi-cycle multiply/divide sequencer owning the HI/LO pair.
//
// Accepts MULT/MULTU/DIV/DIVU, runs 32 iterations of a shared 33-bit
// add/subtract (shift-add multiply, restoring divide) with sign correction
// before and after the loop, and services MTHI/MTLO writes while idle.
//
// Build option: define MDU_DIV_EN to build the DIV/DIVU datapath. Without it,
// a divide start is rejected with a one-cycle op_err pulse and nothing else
// changes.
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous active-low reset
//   start        launch an operation (sampled only while not busy)
//   op[1:0]      00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   A, B         rs / rt operands
//   hi_we, lo_we MTHI / MTLO write strobes (honoured only while not busy)
//   wdata        MTHI / MTLO data
//   busy         operation in flight (PREP, RUN, FIX)
//   done         one-cycle pulse once HI/LO hold the result
//   op_err       one-cycle pulse for a rejected start
//   HI, LO       architectural HI/LO registers

module mdu_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             op_err,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PREP = 3'd1,
        ST_RUN  = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    // Conditional two's-complement negate of a 32-bit word.
    function automatic logic [31:0] cneg32(input logic [31:0] v, input logic en);
        logic [31:0] r;
        if (en) begin
            r = ~v + 32'd1;
        end else begin
            r = v;
        end
        return r;
    endfunction

    // Conditional two's-complement negate of the 64-bit product.
    function automatic logic [63:0] cneg64(input logic [63:0] v, input logic en);
        logic [63:0] r;
        if (en) begin
            r = ~v + 64'd1;
        end else begin
            r = v;
        end
        return r;
    endfunction

    state_t      state_r, state_nxt_s;
    logic        signed_r, signed_nxt_s;   // MULT / DIV (signed flavour)
    logic        rsign_r, rsign_nxt_s;     // result sign A^B (signed ops only)
    logic [31:0] a_r, a_nxt_s;             // raw A until PREP, then |A|
    logic [31:0] b_r, b_nxt_s;             // raw B until PREP, then |B|
    logic [63:0] work_r, work_nxt_s;       // {remainder/product hi, quotient/product lo}
    logic [4:0]  cnt_r, cnt_nxt_s;
    logic [31:0] hi_r, hi_nxt_s;
    logic [31:0] lo_r, lo_nxt_s;
    logic        busy_r, done_r, op_err_r;
    logic        op_err_nxt_s;
    logic        start_ok_s;

    // The one shared adder/subtractor used by every iteration.
    logic [32:0] add_x_s, add_y_s, add_sum_s;
    logic        add_sub_s;

`ifdef MDU_DIV_EN
    logic        div_r, div_nxt_s;         // operation is a divide
    logic        dsign_r, dsign_nxt_s;     // dividend was negative (signed divide)

    assign start_ok_s = 1'b1;
`else
    assign start_ok_s = ~op[1];
`endif

    assign add_sum_s = add_x_s + (add_y_s ^ {33{add_sub_s}}) + {32'd0, add_sub_s};

    // Adder operand selection for the current iteration.
    always_comb begin
        add_x_s   = 33'd0;
        add_y_s   = 33'd0;
        add_sub_s = 1'b0;
        if (state_r == ST_RUN) begin
`ifdef MDU_DIV_EN
            if (div_r) begin
                // Shift the partial remainder left, bring in the next dividend
                // bit (MSB first) and trial-subtract the divisor.
                add_x_s   = {work_r[63:32], a_r[~cnt_r]};
                add_y_s   = {1'b0, b_r};
                add_sub_s = 1'b1;
            end else begin
                add_x_s   = {1'b0, work_r[63:32]};
                add_y_s   = b_r[cnt_r] ? {1'b0, a_r} : 33'd0;
                add_sub_s = 1'b0;
            end
`else
            // Multiplier bits are consumed LSB first, indexed by the counter.
            add_x_s   = {1'b0, work_r[63:32]};
            add_y_s   = b_r[cnt_r] ? {1'b0, a_r} : 33'd0;
            add_sub_s = 1'b0;
`endif
        end else begin
            add_x_s   = 33'd0;
            add_y_s   = 33'd0;
            add_sub_s = 1'b0;
        end
    end

    // Next-state and datapath update logic.
    always_comb begin
        state_nxt_s  = state_r;
        signed_nxt_s = signed_r;
        rsign_nxt_s  = rsign_r;
        a_nxt_s      = a_r;
        b_nxt_s      = b_r;
        work_nxt_s   = work_r;
        cnt_nxt_s    = cnt_r;
        hi_nxt_s     = hi_r;
        lo_nxt_s     = lo_r;
        op_err_nxt_s = 1'b0;
`ifdef MDU_DIV_EN
        div_nxt_s    = div_r;
        dsign_nxt_s  = dsign_r;
`endif
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start && start_ok_s) begin
                    // A start in the same cycle as a write wins; the write is dropped.
                    state_nxt_s  = ST_PREP;
                    signed_nxt_s = ~op[0];
                    a_nxt_s      = A;
                    b_nxt_s      = B;
`ifdef MDU_DIV_EN
                    div_nxt_s    = op[1];
`endif
                end else if (start) begin
                    state_nxt_s  = ST_IDLE;
                    op_err_nxt_s = 1'b1;
                end else begin
                    state_nxt_s = ST_IDLE;
                    if (hi_we) begin
                        hi_nxt_s = wdata;
                    end else begin
                        hi_nxt_s = hi_r;
                    end
                    if (lo_we) begin
                        lo_nxt_s = wdata;
                    end else begin
                        lo_nxt_s = lo_r;
                    end
                end
            end
            ST_PREP: begin
                rsign_nxt_s = signed_r & (a_r[31] ^ b_r[31]);
                a_nxt_s     = cneg32(a_r, signed_r & a_r[31]);
                b_nxt_s     = cneg32(b_r, signed_r & b_r[31]);
                work_nxt_s  = 64'd0;
                cnt_nxt_s   = 5'd0;
`ifdef MDU_DIV_EN
                dsign_nxt_s = signed_r & a_r[31];
                if (div_r && (b_r == 32'd0)) begin
                    // Divide by zero skips the loop; a_r still holds the raw dividend.
                    hi_nxt_s    = a_r;
                    lo_nxt_s    = 32'hFFFF_FFFF;
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_RUN;
                end
`else
                state_nxt_s = ST_RUN;
`endif
            end
            ST_RUN: begin
`ifdef MDU_DIV_EN
                if (div_r) begin
                    // Sum bit 32 is the borrow: set means the trial went negative, so restore.
                    if (add_sum_s[32]) begin
                        work_nxt_s = {add_x_s[31:0], work_r[30:0], 1'b0};
                    end else begin
                        work_nxt_s = {add_sum_s[31:0], work_r[30:0], 1'b1};
                    end
                end else begin
                    work_nxt_s = {add_sum_s, work_r[31:1]};
                end
`else
                work_nxt_s = {add_sum_s, work_r[31:1]};
`endif
                cnt_nxt_s = cnt_r + 5'd1;
                if (cnt_r == 5'd31) begin
                    state_nxt_s = ST_FIX;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_FIX: begin
`ifdef MDU_DIV_EN
                if (div_r) begin
                    // Remainder follows the dividend sign so the quotient truncates toward zero.
                    lo_nxt_s = cneg32(work_r[31:0], rsign_r);
                    hi_nxt_s = cneg32(work_r[63:32], dsign_r);
                end else begin
                    {hi_nxt_s, lo_nxt_s} = cneg64(work_r, rsign_r);
                end
`else
                {hi_nxt_s, lo_nxt_s} = cneg64(work_r, rsign_r);
`endif
                state_nxt_s = ST_DONE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Operand, working register, counter and HI/LO registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            signed_r <= 1'b0;
            rsign_r  <= 1'b0;
            a_r      <= 32'd0;
            b_r      <= 32'd0;
            work_r   <= 64'd0;
            cnt_r    <= 5'd0;
            hi_r     <= 32'd0;
            lo_r     <= 32'd0;
`ifdef MDU_DIV_EN
            div_r    <= 1'b0;
            dsign_r  <= 1'b0;
`endif
        end else begin
            signed_r <= signed_nxt_s;
            rsign_r  <= rsign_nxt_s;
            a_r      <= a_nxt_s;
            b_r      <= b_nxt_s;
            work_r   <= work_nxt_s;
            cnt_r    <= cnt_nxt_s;
            hi_r     <= hi_nxt_s;
            lo_r     <= lo_nxt_s;
`ifdef MDU_DIV_EN
            div_r    <= div_nxt_s;
            dsign_r  <= dsign_nxt_s;
`endif
        end
    end

    // Status outputs, registered from the next state so they align with it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            op_err_r <= 1'b0;
        end else begin
            busy_r   <= (state_nxt_s == ST_PREP) || (state_nxt_s == ST_RUN) ||
                        (state_nxt_s == ST_FIX);
            done_r   <= (state_nxt_s == ST_DONE);
            op_err_r <= op_err_nxt_s;
        end
    end

    assign busy   = busy_r;
    assign done   = done_r;
    assign op_err = op_err_r;
    assign HI     = hi_r;
    assign LO     = lo_r;

endmodule
